// File: rtl/pll_reset_seq_if.sv
// Signal bundle between the PLL reset sequencer and its surroundings:
// PLL lock in, PLL reset and staged subsystem resets plus status out.
interface pll_reset_seq_if;
  logic       locked_in;
  logic       pll_rst;
  logic       rst_video;
  logic       rst_cpu;
  logic       rst_audio;
  logic       ready;
  logic       fail;
  logic [7:0] relock_cnt;

  modport master (
    input  locked_in,
    output pll_rst, rst_video, rst_cpu, rst_audio, ready, fail, relock_cnt
  );

  modport slave (
    output locked_in,
    input  pll_rst, rst_video, rst_cpu, rst_audio, ready, fail, relock_cnt
  );
endinterface

// File: rtl/pll_reset_seq.sv
// Holds the PLL in reset, waits for stable lock, then releases video, CPU and
// audio resets in order; retries on lock timeout and latches a hard failure.
module pll_reset_seq #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 1048576,
  parameter int unsigned LOCK_STABLE    = 1024,
  parameter int unsigned STAGE_GAP      = 256,
  parameter int unsigned RETRY_MAX      = 3
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  pll_reset_seq_if.master seq_if
);

  localparam int unsigned MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_B   = (LOCK_STABLE > STAGE_GAP) ? LOCK_STABLE : STAGE_GAP;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_PLLRST    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_REL_VID   = 3'd3,
    ST_REL_CPU   = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAIL      = 3'd6
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      sat_inc8 = v;
    end else begin
      sat_inc8 = v + 8'd1;
    end
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    relock_q, relock_d;
  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic          pll_rst_q, pll_rst_d;
  logic          rst_video_q, rst_video_d;
  logic          rst_cpu_q, rst_cpu_d;
  logic          rst_audio_q, rst_audio_d;
  logic          ready_q, ready_d;
  logic          fail_q, fail_d;
  logic          locked_s;
  logic          lost_s;
  logic [3:0]    retry_inc_s;

  assign locked_s = sync2_q;

  // State register, counters, synchronizer and registered outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_PLLRST;
      cnt_q       <= '0;
      retry_q     <= 4'd0;
      relock_q    <= 8'd0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      pll_rst_q   <= 1'b1;
      rst_video_q <= 1'b1;
      rst_cpu_q   <= 1'b1;
      rst_audio_q <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      relock_q    <= relock_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      pll_rst_q   <= pll_rst_d;
      rst_video_q <= rst_video_d;
      rst_cpu_q   <= rst_cpu_d;
      rst_audio_q <= rst_audio_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  // Next-state, counter and retry/relock bookkeeping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    retry_d     = retry_q;
    relock_d    = relock_q;
    sync1_d     = seq_if.locked_in;
    sync2_d     = sync1_q;
    lost_s      = 1'b0;
    retry_inc_s = retry_q + 4'd1;
    case (state_q)
      ST_PLLRST: begin
        if (cnt_q == CW'(PLL_RST_CYCLES - 1)) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          state_d = ST_PLLRST;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock seen in the same cycle as the timeout still wins.
        if (locked_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          retry_d = retry_inc_s;
          if (retry_inc_s == 4'(RETRY_MAX)) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_PLLRST;
          end
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == CW'(LOCK_STABLE - 1)) begin
          state_d = ST_REL_VID;
        end else begin
          state_d = ST_STABLE;
        end
      end
      ST_REL_VID: begin
        if (!locked_s) begin
          lost_s = 1'b1;
        end else if (cnt_q == CW'(STAGE_GAP - 1)) begin
          state_d = ST_REL_CPU;
        end else begin
          state_d = ST_REL_VID;
        end
      end
      ST_REL_CPU: begin
        if (!locked_s) begin
          lost_s = 1'b1;
        end else if (cnt_q == CW'(STAGE_GAP - 1)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_REL_CPU;
        end
      end
      ST_RUN: begin
        retry_d = 4'd0;
        if (!locked_s) begin
          lost_s = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_PLLRST;
      end
    endcase

    if (lost_s) begin
      state_d  = ST_WAIT_LOCK;
      relock_d = sat_inc8(relock_q);
    end else begin
      relock_d = relock_q;
    end

    // Counter only runs in timed states and restarts on every transition.
    if ((state_d != state_q) || (state_q == ST_RUN) || (state_q == ST_FAIL)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Output values decoded from the state being entered.
  always_comb begin
    pll_rst_d   = 1'b0;
    rst_video_d = 1'b1;
    rst_cpu_d   = 1'b1;
    rst_audio_d = 1'b1;
    ready_d     = 1'b0;
    fail_d      = 1'b0;
    case (state_d)
      ST_PLLRST:    pll_rst_d = 1'b1;
      ST_WAIT_LOCK: pll_rst_d = 1'b0;
      ST_STABLE:    pll_rst_d = 1'b0;
      ST_REL_VID:   rst_video_d = 1'b0;
      ST_REL_CPU: begin
        rst_video_d = 1'b0;
        rst_cpu_d   = 1'b0;
      end
      ST_RUN: begin
        rst_video_d = 1'b0;
        rst_cpu_d   = 1'b0;
        rst_audio_d = 1'b0;
        ready_d     = 1'b1;
      end
      ST_FAIL:      fail_d = 1'b1;
      default:      pll_rst_d = 1'b1;
    endcase
  end

  assign seq_if.pll_rst    = pll_rst_q;
  assign seq_if.rst_video  = rst_video_q;
  assign seq_if.rst_cpu    = rst_cpu_q;
  assign seq_if.rst_audio  = rst_audio_q;
  assign seq_if.ready      = ready_q;
  assign seq_if.fail       = fail_q;
  assign seq_if.relock_cnt = relock_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq: an event-time reference model queues the
// expected outputs after every clock edge and a monitor compares them.
module tb_pll_reset_seq;
  localparam int PRC  = 4;
  localparam int LTO  = 64;
  localparam int LST  = 8;
  localparam int GAP  = 4;
  localparam int RMAX = 2;
  localparam logic [13:0] RESET_VEC = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};

  logic clk_sys = 1'b0;
  logic reset_n = 1'b1;
  int   passed  = 0;
  int   total   = 0;
  int   cyc     = 0;
  logic [13:0] exp_q[$];

  pll_reset_seq_if rs_if();

  pll_reset_seq #(
    .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(LTO), .LOCK_STABLE(LST),
    .STAGE_GAP(GAP), .RETRY_MAX(RMAX)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .seq_if (rs_if)
  );

  always #5 clk_sys = ~clk_sys;

  typedef enum {M_PLLRST, M_WAIT, M_STABLE, M_VID, M_CPU, M_RUN, M_FAIL} mphase_e;

  function automatic logic [13:0] outvec();
    return {rs_if.pll_rst, rs_if.rst_video, rs_if.rst_cpu, rs_if.rst_audio,
            rs_if.ready, rs_if.fail, rs_if.relock_cnt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s at edge %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: phase plus the edge it was entered at; lock seen is the
  // input sampled two edges earlier.
  initial begin : model
    mphase_e ph;
    int entered, tries, losses;
    bit hist[$];
    bit seen;
    ph = M_PLLRST; entered = 0; tries = 0; losses = 0;
    forever begin
      @(posedge clk_sys or negedge reset_n);
      if (!reset_n) begin
        ph = M_PLLRST; entered = 0; tries = 0; losses = 0;
        hist.delete(); exp_q.delete(); cyc = 0;
      end else begin
        cyc++;
        seen = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
        hist.push_back(rs_if.locked_in);
        if (hist.size() > 4) void'(hist.pop_front());
        case (ph)
          M_PLLRST: if (cyc - entered == PRC) begin ph = M_WAIT; entered = cyc; end
          M_WAIT: begin
            if (seen) begin ph = M_STABLE; entered = cyc; end
            else if (cyc - entered == LTO) begin
              tries++;
              ph = (tries == RMAX) ? M_FAIL : M_PLLRST;
              entered = cyc;
            end
          end
          M_STABLE: begin
            if (!seen) begin ph = M_WAIT; entered = cyc; end
            else if (cyc - entered == LST) begin ph = M_VID; entered = cyc; end
          end
          M_VID, M_CPU, M_RUN: begin
            if (!seen) begin
              if (losses < 255) losses++;
              ph = M_WAIT; entered = cyc;
            end else if (ph != M_RUN && cyc - entered == GAP) begin
              ph = (ph == M_VID) ? M_CPU : M_RUN;
              entered = cyc;
              if (ph == M_RUN) tries = 0;
            end
          end
          default: ;
        endcase
        exp_q.push_back({ph == M_PLLRST,
                         !(ph inside {M_VID, M_CPU, M_RUN}),
                         !(ph inside {M_CPU, M_RUN}),
                         ph != M_RUN,
                         ph == M_RUN,
                         ph == M_FAIL,
                         8'(losses)});
      end
    end
  end

  // Monitor: compares the DUT against the queued expectation every cycle.
  initial begin : monitor
    logic [13:0] e;
    forever begin
      @(negedge clk_sys);
      if (reset_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", 32'(outvec()), 32'(e));
        check("release_order",
              32'((rs_if.rst_audio || !rs_if.rst_cpu) && (rs_if.rst_cpu || !rs_if.rst_video)),
              32'd1);
      end
    end
  end

  task automatic at_edge(input int k);
    while (cyc < k) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    rs_if.locked_in = 1'b0;
    #1;
    check("async_reset", 32'(outvec()), 32'(RESET_VEC));
    repeat (3) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin : stim
    int t;
    rs_if.locked_in = 1'b0;
    #1 reset_n = 1'b0;
    #2 check("reset_state", 32'(outvec()), 32'(RESET_VEC));
    @(posedge clk_sys);
    #1 reset_n = 1'b1;

    // Clean lock
    at_edge(3);  check("pll_rst_hold", 32'(rs_if.pll_rst), 32'd1);
    at_edge(4);  check("pll_rst_fall", 32'(rs_if.pll_rst), 32'd0);
    at_edge(10); rs_if.locked_in = 1'b1;
    at_edge(20); check("video_before", 32'(rs_if.rst_video), 32'd1);
    at_edge(21); check("video_fall", 32'({rs_if.rst_video, rs_if.rst_cpu}), 32'b01);
    at_edge(24); check("cpu_before", 32'(rs_if.rst_cpu), 32'd1);
    at_edge(25); check("cpu_fall", 32'({rs_if.rst_cpu, rs_if.rst_audio}), 32'b01);
    at_edge(28); check("ready_before", 32'({rs_if.ready, rs_if.rst_audio}), 32'b01);
    at_edge(29); check("ready_rise", 32'({rs_if.ready, rs_if.rst_audio, rs_if.relock_cnt}), {22'd0, 2'b10, 8'd0});

    // One-cycle lock loss in RUN
    at_edge(40); rs_if.locked_in = 1'b0;
    at_edge(41); rs_if.locked_in = 1'b1;
    at_edge(42); check("run_before_loss", 32'(rs_if.ready), 32'd1);
    at_edge(43); check("loss_resets", 32'({rs_if.ready, rs_if.rst_video, rs_if.rst_cpu, rs_if.rst_audio, rs_if.relock_cnt}),
                       {20'd0, 4'b0111, 8'd1});
    at_edge(59); check("rerun_before", 32'(rs_if.ready), 32'd0);
    at_edge(60); check("rerun_ready", 32'(rs_if.ready), 32'd1);

    // Glitchy lock
    at_edge(70); rs_if.locked_in = 1'b0;
    at_edge(80); rs_if.locked_in = 1'b1;
    at_edge(85); rs_if.locked_in = 1'b0;
    at_edge(88); check("glitch_no_release", 32'(rs_if.rst_video), 32'd1);
    at_edge(95); rs_if.locked_in = 1'b1;
    at_edge(105); check("glitch_video_before", 32'(rs_if.rst_video), 32'd1);
    at_edge(106); check("glitch_video_fall", 32'(rs_if.rst_video), 32'd0);
    at_edge(113); check("glitch_ready_before", 32'(rs_if.ready), 32'd0);
    at_edge(114); check("glitch_ready", 32'({rs_if.ready, rs_if.relock_cnt}), {23'd0, 1'b1, 8'd2});

    // Random lock/unlock episodes, checked by the model only
    for (int i = 0; i < 40; i++) begin
      rs_if.locked_in = 1'b1;
      t = cyc + int'($urandom_range(1, 30));
      at_edge(t);
      rs_if.locked_in = 1'b0;
      t = cyc + int'($urandom_range(1, 90));
      at_edge(t);
    end

    // Saturation of the relock counter
    do_reset();
    for (int i = 0; i < 260; i++) begin
      rs_if.locked_in = 1'b1;
      at_edge(cyc + 14);
      rs_if.locked_in = 1'b0;
      at_edge(cyc + 4);
    end
    check("relock_saturated", 32'(rs_if.relock_cnt), 32'd255);

    // Asynchronous reset in the middle of REL_CPU
    rs_if.locked_in = 1'b1;
    at_edge(cyc + 16);
    check("in_rel_cpu", 32'({rs_if.rst_video, rs_if.rst_cpu, rs_if.rst_audio}), 32'b001);
    do_reset();

    // Timeout, retry and terminal failure
    at_edge(67);  check("tmo_before", 32'(rs_if.pll_rst), 32'd0);
    at_edge(68);  check("tmo_pll_rst", 32'({rs_if.pll_rst, rs_if.fail}), 32'b10);
    at_edge(71);  check("tmo_pulse_hold", 32'(rs_if.pll_rst), 32'd1);
    at_edge(72);  check("tmo_pulse_end", 32'(rs_if.pll_rst), 32'd0);
    at_edge(135); check("fail_before", 32'(rs_if.fail), 32'd0);
    at_edge(136); check("fail_set", 32'({rs_if.fail, rs_if.pll_rst}), 32'b10);
    at_edge(140); rs_if.locked_in = 1'b1;
    at_edge(200); check("fail_sticky", 32'({rs_if.fail, rs_if.pll_rst, rs_if.ready, rs_if.rst_video}), 32'b1001);

    @(negedge clk_sys);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Absolute time limit so a stuck run still reports.
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/pll_reset_seq.md
# pll_reset_seq

Reset sequencer that consumes the PLL `locked` output, drives the PLL `rst` input, and releases the core's per-subsystem resets in a fixed order once lock is stable. It sits between the clock-generation block and the core top level, in the `clk_sys` domain (48 MHz PLL output). It retries PLL reset on lock timeout, re-sequences on lock loss, and reports a hard failure after repeated timeouts.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per PLL reset pulse (≥1).
- `LOCK_TIMEOUT`, 1048576: cycles allowed in WAIT_LOCK before retrying (≥2).
- `LOCK_STABLE`, 1024: cycles synchronized lock must stay high before the first release (≥1).
- `STAGE_GAP`, 256: cycles between successive reset releases (≥1).
- `RETRY_MAX`, 3: consecutive timeouts before FAIL (1..15).

Ports:
- `clk_sys` in 1: system clock; all logic rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `locked_in` in 1: PLL lock, asynchronous to `clk_sys`.
- `pll_rst` out 1: active-high reset to the PLL.
- `rst_video` out 1: active-high video reset.
- `rst_cpu` out 1: active-high CPU reset.
- `rst_audio` out 1: active-high audio reset.
- `ready` out 1: high only in RUN.
- `fail` out 1: high only in FAIL.
- `relock_cnt` out 8: count of lock losses after first release; saturates at 255.

## Operation
- `locked_in` passes through a 2-flop synchronizer to give `locked_s`; only `locked_s` is used.
- Reset values: state PLLRST, `pll_rst`=1, `rst_video`=`rst_cpu`=`rst_audio`=1, `ready`=0, `fail`=0, `relock_cnt`=0, cycle counter 0, retry counter 0, synchronizer 0. All outputs are registered.
- PLLRST: `pll_rst`=1, all resets high. After `PLL_RST_CYCLES` cycles -> WAIT_LOCK, `pll_rst`=0, counter cleared.
- WAIT_LOCK: if `locked_s` -> STABLE, counter cleared. Otherwise, when the counter reaches `LOCK_TIMEOUT`-1, increment retry; if the new retry equals `RETRY_MAX` -> FAIL, else -> PLLRST. Lock takes priority over a simultaneous timeout.
- STABLE: `locked_s` low -> WAIT_LOCK, counter cleared, retry unchanged. After `LOCK_STABLE` consecutive high cycles -> REL_VID.
- REL_VID: `rst_video`=0. After `STAGE_GAP` cycles -> REL_CPU.
- REL_CPU: `rst_cpu`=0 as well. After `STAGE_GAP` cycles -> RUN.
- RUN: `rst_audio`=0, `ready`=1, retry cleared.
- Lock loss in REL_VID, REL_CPU or RUN: all three resets return high, `ready`=0, `relock_cnt` increments (saturating), and the state goes to WAIT_LOCK with the counter cleared. Lock loss wins over a stage advance in the same cycle.
- FAIL: terminal until `reset_n`. `pll_rst`=0, all resets high, `fail`=1.
- Counter width covers the largest parameter (`$clog2`). It is cleared on every state change.

## Timing
- Synchronizer latency is 2 cycles: a `locked_in` edge at clock edge t appears in `locked_s` after edge t+2. The state reacts at edge t+3.
- After reset: `pll_rst` falls at edge `PLL_RST_CYCLES`.
- Lock path: with `locked_s` first high at edge L, STABLE is entered at L+1.
  - `rst_video` falls at L+1+`LOCK_STABLE`.
  - `rst_cpu` falls `STAGE_GAP` cycles later.
  - `rst_audio` falls and `ready` rises 2×`STAGE_GAP` cycles after `rst_video`.
- Lock loss: `locked_in` low at edge t -> resets high and `ready` low at edge t+3. The release order never inverts: at every cycle, `rst_audio`=0 implies `rst_cpu`=0, and `rst_cpu`=0 implies `rst_video`=0.
- Timeout path: `pll_rst` rises on the edge after the counter reaches `LOCK_TIMEOUT`-1.
- `reset_n` assertion mid-sequence forces all reset values immediately (asynchronously).

## Test plan
Bench parameters: `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT`=64, `LOCK_STABLE`=8, `STAGE_GAP`=4, `RETRY_MAX`=2.
- Clean lock: release `reset_n`, raise `locked_in` at cycle 10 -> `pll_rst` low at cycle 4; `rst_video` low at cycle 21; `rst_cpu` low at 25; `rst_audio` low and `ready` high at 29; `relock_cnt`=0.
- Glitchy lock: pulse `locked_in` high for 5 cycles, then low, then hold it high -> no reset release during the pulse; the sequence restarts and completes 8+8 cycles after the stable high is synchronized.
- Lock loss in RUN: drop `locked_in` for 1 cycle -> all resets high and `ready` low 3 cycles later; `relock_cnt`=1; the full sequence re-runs once lock returns.
- Timeout retry: keep `locked_in` low -> `pll_rst` pulses high for 4 cycles after 64 WAIT_LOCK cycles. After the second timeout, `fail`=1 and `pll_rst`=0 permanently, and a later `locked_in` high is ignored.
- Saturation and async reset: cause 260 lock losses -> `relock_cnt` holds 255. Assert `reset_n` low mid-REL_CPU -> all outputs return to their reset values without waiting for a clock edge.
